// File: rtl/halt_dump_pkg.sv
// Shared record-kind codes and FSM state type for the post-halt dump unit.
`timescale 1ns/1ps
package halt_dump_pkg;

    localparam logic [1:0] KIND_CYCLE   = 2'd0;
    localparam logic [1:0] KIND_REG     = 2'd1;
    localparam logic [1:0] KIND_INSTRET = 2'd2;

    typedef enum logic [2:0] {
        RUN,
        EMIT_CYC,
        EMIT_REG,
        EMIT_INSTRET,
        DONE
    } state_e;

endpackage

// File: rtl/halt_dump_unit_sat_counter.sv
// Saturating up-counter; stops at all-ones and holds while frozen.
`timescale 1ns/1ps
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_freeze,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = &r_cnt;
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && !i_freeze && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/halt_dump_unit.sv
// Counts cycles until CPU halt, then streams cycle count and register file.
// HALT_DUMP_INSTRET_EN adds a retire input and a trailing instret record.
`timescale 1ns/1ps
module halt_dump_unit
    import halt_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int CNT_W    = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            is_halted,
`ifdef HALT_DUMP_INSTRET_EN
    input  logic            retire,
`endif
    output logic [AW-1:0]   rf_rd_addr,
    input  logic [XLEN-1:0] rf_rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      out_kind,
    output logic [AW-1:0]   out_idx,
    output logic [XLEN-1:0] out_data,
    output logic            done
);

    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

    state_e            r_state;
    logic              r_valid;
    logic [1:0]        r_kind;
    logic [AW-1:0]     r_idx;
    logic [XLEN-1:0]   r_data;
    logic              r_done;
    logic [AW-1:0]     r_rd_addr;

    logic [CNT_W-1:0]  w_cyc_cnt;
    logic              w_freeze;
    logic              w_hs;
    logic [AW-1:0]     w_next_addr;

    assign w_freeze    = (r_state != RUN);
    assign w_hs        = r_valid && out_ready;
    assign w_next_addr = (r_rd_addr == LAST) ? '0 : r_rd_addr + AW'(1);

    sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .i_en     (1'b1),
        .i_freeze (w_freeze),
        .o_cnt    (w_cyc_cnt)
    );

`ifdef HALT_DUMP_INSTRET_EN
    logic [CNT_W-1:0] w_ret_cnt;

    sat_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .i_en     (retire),
        .i_freeze (w_freeze),
        .o_cnt    (w_ret_cnt)
    );
`endif

    // rf_rd_addr always points at the register to load on the next handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= RUN;
            r_valid   <= 1'b0;
            r_kind    <= KIND_CYCLE;
            r_idx     <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (is_halted) begin
                        r_valid <= 1'b1;
                        r_kind  <= KIND_CYCLE;
                        r_idx   <= '0;
                        r_data  <= XLEN'(w_cyc_cnt);
                        r_state <= EMIT_CYC;
                    end
                end
                EMIT_CYC: begin
                    if (w_hs) begin
                        r_kind    <= KIND_REG;
                        r_idx     <= r_rd_addr;
                        r_data    <= rf_rd_data;
                        r_rd_addr <= w_next_addr;
                        r_state   <= EMIT_REG;
                    end
                end
                EMIT_REG: begin
                    if (w_hs) begin
                        if (r_idx == LAST) begin
`ifdef HALT_DUMP_INSTRET_EN
                            r_kind  <= KIND_INSTRET;
                            r_idx   <= '0;
                            r_data  <= XLEN'(w_ret_cnt);
                            r_state <= EMIT_INSTRET;
`else
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
`endif
                        end else begin
                            r_idx     <= r_rd_addr;
                            r_data    <= rf_rd_data;
                            r_rd_addr <= w_next_addr;
                        end
                    end
                end
                EMIT_INSTRET: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign rf_rd_addr = r_rd_addr;
    assign out_valid  = r_valid;
    assign out_kind   = r_kind;
    assign out_idx    = r_idx;
    assign out_data   = r_data;
    assign done       = r_done;

endmodule

// File: tb/tb_halt_dump_unit.sv
// Scoreboard bench for halt_dump_unit: expected records queued at halt,
// popped on every handshake; a CNT_W=4 instance covers saturation.
`timescale 1ns/1ps
module tb_halt_dump_unit;
    import halt_dump_pkg::*;

    localparam int NR = 32;
    localparam int XL = 32;
    localparam int AW = 5;
`ifdef HALT_DUMP_INSTRET_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic [1:0]    kind;
        logic [AW-1:0] idx;
        logic [XL-1:0] data;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset      = 1'b0;
    logic          is_halted  = 1'b0;
    logic          is_halted4 = 1'b0;
    logic          out_ready  = 1'b0;
`ifdef HALT_DUMP_INSTRET_EN
    logic          retire     = 1'b0;
`endif
    logic [AW-1:0] rf_rd_addr, rf_rd_addr4, out_idx, out_idx4;
    logic [XL-1:0] rf_rd_data, rf_rd_data4, out_data, out_data4;
    logic [1:0]    out_kind, out_kind4;
    logic          out_valid, out_valid4, done, done4;

    logic [XL-1:0] rf_mem [NR];
    assign rf_rd_data  = rf_mem[rf_rd_addr];
    assign rf_rd_data4 = rf_mem[rf_rd_addr4];

    halt_dump_unit dut (
        .clk        (clk),
        .reset      (reset),
        .is_halted  (is_halted),
`ifdef HALT_DUMP_INSTRET_EN
        .retire     (retire),
`endif
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_idx    (out_idx),
        .out_data   (out_data),
        .done       (done)
    );

    halt_dump_unit #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .is_halted  (is_halted4),
`ifdef HALT_DUMP_INSTRET_EN
        .retire     (1'b0),
`endif
        .rf_rd_addr (rf_rd_addr4),
        .rf_rd_data (rf_rd_data4),
        .out_valid  (out_valid4),
        .out_ready  (1'b1),
        .out_kind   (out_kind4),
        .out_idx    (out_idx4),
        .out_data   (out_data4),
        .done       (done4)
    );

    int   checks = 0;
    int   errors = 0;
    rec_t sb [$];
    bit   mon_en = 1'b0;
    bit   stall_prev = 1'b0;
    rec_t held;
    int   exp_instret = 0;

    // Handshake monitor: pops expected records and checks stall stability
    always @(negedge clk) begin
        rec_t cur;
        rec_t exp_r;
        cur = {out_kind, out_idx, out_data};
        if (!reset || !mon_en) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid) begin
                checks++;
                if (cur !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h want %h", cur, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_record got %h want none", cur);
                end else begin
                    exp_r = sb.pop_front();
                    if (cur !== exp_r) begin
                        errors++;
                        $display("FAIL record got %h want %h", cur, exp_r);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held = cur;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        is_halted = 1'b0;
        is_halted4 = 1'b0;
        mon_en = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic push_stream(input int cyc);
        sb.push_back({KIND_CYCLE, AW'(0), XL'(cyc)});
        for (int i = 0; i < NR; i++)
            sb.push_back({KIND_REG, AW'(i), rf_mem[i]});
`ifdef HALT_DUMP_INSTRET_EN
        sb.push_back({KIND_INSTRET, AW'(0), XL'(exp_instret)});
`endif
    endtask

    task automatic halt_at(input int n);
        is_halted = 1'b0;
        repeat (n - 1) @(posedge clk);
        #1;
        is_halted = 1'b1;
        @(posedge clk);
        #1;
        is_halted = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_kind !== KIND_CYCLE) begin
            errors++;
            $display("FAIL valid_after_halt got v=%b k=%0d want v=1 k=0",
                     out_valid, out_kind);
        end
    endtask

    task automatic wait_done(input bit toggle, output int cycles);
        cycles = 0;
        while (!done && cycles < 500) begin
            @(posedge clk);
            #1;
            cycles++;
            if (toggle) out_ready = ~out_ready;
        end
        checks++;
        if (done !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_complete got done=%b left=%0d want 1/0",
                     done, sb.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got v=%b d=%b want 0/0", out_valid, done);
        end
        checks++;
        if (out_kind !== 2'd0 || out_idx !== '0) begin
            errors++;
            $display("FAIL rst_kind_idx got %0d/%0d want 0/0", out_kind, out_idx);
        end
        checks++;
        if (out_data !== '0 || rf_rd_addr !== '0) begin
            errors++;
            $display("FAIL rst_data_addr got %h/%0d want 0/0", out_data, rf_rd_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_dump();
        int cyc;
        for (int i = 0; i < NR; i++) rf_mem[i] = XL'(i * 4);
        do_reset();
        out_ready = 1'b1;
        push_stream(9);
        halt_at(10);
        wait_done(1'b0, cyc);
        checks++;
        if (cyc != NR + 1 + EXTRA) begin
            errors++;
            $display("FAIL done_latency got %0d want %0d", cyc, NR + 1 + EXTRA);
        end
        is_halted = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        is_halted = 1'b0;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky got d=%b v=%b want 1/0", done, out_valid);
        end
    endtask

    task automatic test_stall();
        int cyc;
        for (int i = 0; i < NR; i++)
            rf_mem[i] = XL'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        do_reset();
        out_ready = 1'b1;
        push_stream(6);
        halt_at(7);
        wait_done(1'b1, cyc);
        out_ready = 1'b1;
    endtask

    task automatic test_first_edge();
        int cyc;
        for (int i = 0; i < NR; i++) rf_mem[i] = ~XL'(i);
        do_reset();
        out_ready = 1'b1;
        push_stream(0);
        halt_at(1);
        wait_done(1'b0, cyc);
    endtask

    task automatic test_reset_mid();
        int t;
        int cyc;
        for (int i = 0; i < NR; i++) rf_mem[i] = XL'(i * 4);
        do_reset();
        out_ready = 1'b1;
        push_stream(19);
        halt_at(20);
        t = 0;
        while (!(out_valid && out_kind == KIND_REG && out_idx == 5'd15) && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL reach_reg15 got timeout want reg 15 record");
        end
        #1;
        reset = 1'b0;
        mon_en = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_abort got v=%b d=%b want 0/0", out_valid, done);
        end
        checks++;
        if (out_data !== '0 || rf_rd_addr !== '0 || out_kind !== 2'd0) begin
            errors++;
            $display("FAIL abort_clear got %h/%0d/%0d want 0/0/0",
                     out_data, rf_rd_addr, out_kind);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        push_stream(4);
        halt_at(5);
        wait_done(1'b0, cyc);
    endtask

    task automatic test_saturate();
        int t;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        is_halted4 = 1'b1;
        @(posedge clk);
        #1;
        is_halted4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b1 || out_kind4 !== KIND_CYCLE || out_data4 !== 32'd15) begin
            errors++;
            $display("FAIL sat_cycle got v=%b k=%0d d=%0d want 1/0/15",
                     out_valid4, out_kind4, out_data4);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_kind4 !== KIND_REG || out_idx4 !== '0 || out_data4 !== rf_mem[0]) begin
            errors++;
            $display("FAIL sat_reg0 got %0d/%0d/%h want 1/0/%h",
                     out_kind4, out_idx4, out_data4, rf_mem[0]);
        end
        t = 0;
        while (!done4 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        checks++;
        if (done4 !== 1'b1) begin
            errors++;
            $display("FAIL sat_done got %b want 1", done4);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_spurious got v=%b want 0", out_valid);
        end
    endtask

`ifdef HALT_DUMP_INSTRET_EN
    task automatic test_instret();
        int cyc;
        for (int i = 0; i < NR; i++) rf_mem[i] = XL'(i + 100);
        do_reset();
        out_ready = 1'b1;
        exp_instret = 7;
        push_stream(10);
        for (int k = 1; k <= 11; k++) begin
            retire = (k == 2 || k == 3 || k == 5 || k == 7 ||
                      k == 8 || k == 10 || k == 11);
            is_halted = (k == 11);
            @(posedge clk);
            #1;
        end
        is_halted = 1'b0;
        retire = 1'b1;
        wait_done(1'b0, cyc);
        retire = 1'b0;
        exp_instret = 0;
    endtask
`endif

    initial begin
        for (int i = 0; i < NR; i++) rf_mem[i] = '0;
        test_reset();
        test_dump();
        test_stall();
        test_first_edge();
        test_reset_mid();
        test_saturate();
`ifdef HALT_DUMP_INSTRET_EN
        test_instret();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
